// File: rtl/riscv_memory_pkg.sv
// Shared types and encodings for the RV32I memory stage.
// Holds the EX/MEM register layout, access-size encodings, load funct3 codes and FSM states.
package riscv_memory_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;

  localparam logic [3:0] BYTE_SEL_B = 4'b0001;
  localparam logic [3:0] BYTE_SEL_H = 4'b0011;
  localparam logic [3:0] BYTE_SEL_W = 4'b1111;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TOUT = 2'd2
  } state_e;

  typedef struct packed {
    logic            reg_wr_en;
    logic [1:0]      result_src;
    logic            mem_wr_en;
    logic [3:0]      byte_sel;
    logic [2:0]      funct3;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
  } exmem_t;

  // Operates on read data that has already been shifted down to lane 0.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                  input logic [XLEN-1:0] data);
    logic [XLEN-1:0] r;
    r = '0;
    unique case (funct3)
      FUNCT3_LOAD_LB:  r = {{(XLEN-8){data[7]}}, data[7:0]};
      FUNCT3_LOAD_LH:  r = {{(XLEN-16){data[15]}}, data[15:0]};
      FUNCT3_LOAD_LW:  r = data;
      FUNCT3_LOAD_LBU: r = {{(XLEN-8){1'b0}}, data[7:0]};
      FUNCT3_LOAD_LHU: r = {{(XLEN-16){1'b0}}, data[15:0]};
      default:         r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_memory_pipeline.sv
// EX/MEM pipeline register: loads every cycle unless held, synchronous active-high reset.
module pipeline_memory
  import riscv_memory_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   hold_i,
  input  exmem_t d_i,
  output exmem_t q_o
);

  exmem_t exmem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exmem_q <= '0;
    end else if (!hold_i) begin
      exmem_q <= d_i;
    end
  end

  assign q_o = exmem_q;

endmodule

// File: rtl/riscv_memory.sv
// Memory stage of the 5-stage RV32I pipeline: EX/MEM register, req/ack data bus,
// store lane alignment, load extraction/extension and wait/timeout handling.
module riscv_memory
  import riscv_memory_pkg::*;
#(
  parameter int unsigned P_TIMEOUT = 16,
  parameter int unsigned P_CNT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ctrl_reg_wr_enE,
  input  logic [1:0]      i_ctrl_result_srcE,
  input  logic            i_ctrl_mem_wr_enE,
  input  logic [3:0]      i_ctrl_mem_byte_selE,
  input  logic [2:0]      i_ctrl_funct3E,
  input  logic [4:0]      i_regfile_rd_addrE,
  input  logic [XLEN-1:0] i_alu_resultE,
  input  logic [XLEN-1:0] i_mem_writedataE,
  input  logic [XLEN-1:0] i_PCPlus4E,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_dmem_req,
  output logic            o_dmem_wr_en,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_byte_en,
  output logic            o_ctrl_reg_wr_enM,
  output logic [1:0]      o_ctrl_result_srcM,
  output logic [4:0]      o_regfile_rd_addrM,
  output logic [XLEN-1:0] o_alu_resultM,
  output logic [XLEN-1:0] o_read_dataM,
  output logic [XLEN-1:0] o_PCPlus4M,
  output logic            o_stallM,
  output logic            o_misalignM,
  output logic            o_bus_errM
);

  localparam logic [P_CNT_W-1:0] TOUT_CNT = P_CNT_W'(P_TIMEOUT);

  exmem_t              ex_d;
  exmem_t              m_q;
  state_e              state_q, state_d;
  logic [P_CNT_W-1:0]  cnt_q, cnt_d;

  logic                is_load, memop, is_half, is_word, mis, aligned;
  logic [1:0]          off;
  logic                req, stall;
  logic [XLEN-1:0]     wdata, rdata_shifted;

  assign ex_d = '{
    reg_wr_en:  i_ctrl_reg_wr_enE,
    result_src: i_ctrl_result_srcE,
    mem_wr_en:  i_ctrl_mem_wr_enE,
    byte_sel:   i_ctrl_mem_byte_selE,
    funct3:     i_ctrl_funct3E,
    rd_addr:    i_regfile_rd_addrE,
    alu_result: i_alu_resultE,
    write_data: i_mem_writedataE,
    pc_plus4:   i_PCPlus4E
  };

  pipeline_memory u_exmem (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .hold_i (stall),
    .d_i    (ex_d),
    .q_o    (m_q)
  );

  assign off     = m_q.alu_result[1:0];
  assign is_load = (m_q.result_src == RESULT_SRC_LOAD);
  assign memop   = is_load | m_q.mem_wr_en;
  assign is_half = (m_q.byte_sel == BYTE_SEL_H);
  assign is_word = (m_q.byte_sel == BYTE_SEL_W);
  assign mis     = memop & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign aligned = memop & ~mis;

  always_comb begin
    wdata = '0;
    if (m_q.mem_wr_en) begin
      unique case (m_q.byte_sel)
        BYTE_SEL_B: wdata = {4{m_q.write_data[7:0]}};
        BYTE_SEL_H: wdata = {2{m_q.write_data[15:0]}};
        default:    wdata = m_q.write_data;
      endcase
    end
  end

  assign rdata_shifted = i_dmem_rdata >> {off, 3'b000};

  // In the final wait cycle the request stays up but the stall drops, so the
  // timeout cycle that follows already sees the next instruction in M.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req = aligned;
        if (aligned && !i_dmem_ack) begin
          stall   = 1'b1;
          cnt_d   = P_CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (i_dmem_ack) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == TOUT_CNT) begin
          cnt_d   = '0;
          state_d = S_TOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          stall = 1'b1;
        end
      end
      S_TOUT: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_dmem_req         = req;
  assign o_dmem_wr_en       = req & m_q.mem_wr_en;
  assign o_dmem_addr        = {m_q.alu_result[XLEN-1:2], 2'b00};
  assign o_dmem_wdata       = wdata;
  assign o_dmem_byte_en     = m_q.byte_sel << off;

  assign o_ctrl_reg_wr_enM  = m_q.reg_wr_en & ~mis & (state_q != S_TOUT);
  assign o_ctrl_result_srcM = m_q.result_src;
  assign o_regfile_rd_addrM = m_q.rd_addr;
  assign o_alu_resultM      = m_q.alu_result;
  assign o_PCPlus4M         = m_q.pc_plus4;
  assign o_read_dataM       = (req & i_dmem_ack & is_load) ? load_extend(m_q.funct3, rdata_shifted) : '0;

  assign o_stallM           = stall;
  assign o_misalignM        = mis;
  assign o_bus_errM         = (state_q == S_TOUT);

endmodule

// File: tb/tb_riscv_memory.sv
// Self-checking bench for riscv_memory: directed scenarios plus randomized ops
// checked against a byte-level behavioural model.
module tb_riscv_memory;

  localparam int unsigned TOUT = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_ctrl_reg_wr_enE;
  logic [1:0]  i_ctrl_result_srcE;
  logic        i_ctrl_mem_wr_enE;
  logic [3:0]  i_ctrl_mem_byte_selE;
  logic [2:0]  i_ctrl_funct3E;
  logic [4:0]  i_regfile_rd_addrE;
  logic [31:0] i_alu_resultE, i_mem_writedataE, i_PCPlus4E;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_dmem_req, o_dmem_wr_en;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_byte_en;
  logic        o_ctrl_reg_wr_enM;
  logic [1:0]  o_ctrl_result_srcM;
  logic [4:0]  o_regfile_rd_addrM;
  logic [31:0] o_alu_resultM, o_read_dataM, o_PCPlus4M;
  logic        o_stallM, o_misalignM, o_bus_errM;

  logic [5:0]  ctl;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  riscv_memory #(.P_TIMEOUT(TOUT), .P_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_ctrl_reg_wr_enE(i_ctrl_reg_wr_enE), .i_ctrl_result_srcE(i_ctrl_result_srcE),
    .i_ctrl_mem_wr_enE(i_ctrl_mem_wr_enE), .i_ctrl_mem_byte_selE(i_ctrl_mem_byte_selE),
    .i_ctrl_funct3E(i_ctrl_funct3E), .i_regfile_rd_addrE(i_regfile_rd_addrE),
    .i_alu_resultE(i_alu_resultE), .i_mem_writedataE(i_mem_writedataE), .i_PCPlus4E(i_PCPlus4E),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_dmem_req(o_dmem_req), .o_dmem_wr_en(o_dmem_wr_en), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_byte_en(o_dmem_byte_en),
    .o_ctrl_reg_wr_enM(o_ctrl_reg_wr_enM), .o_ctrl_result_srcM(o_ctrl_result_srcM),
    .o_regfile_rd_addrM(o_regfile_rd_addrM), .o_alu_resultM(o_alu_resultM),
    .o_read_dataM(o_read_dataM), .o_PCPlus4M(o_PCPlus4M),
    .o_stallM(o_stallM), .o_misalignM(o_misalignM), .o_bus_errM(o_bus_errM)
  );

  assign ctl = {o_dmem_req, o_dmem_wr_en, o_stallM, o_misalignM, o_bus_errM, o_ctrl_reg_wr_enM};

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(input int unsigned nb, input logic [31:0] a);
    logic [3:0] be;
    int unsigned o;
    be = '0;
    o  = a % 4;
    for (int unsigned b = 0; b < 4; b++) be[b] = (b >= o) && (b < o + nb);
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input int unsigned nb, input logic [31:0] wd);
    logic [31:0] r;
    r = '0;
    if (nb != 0)
      for (int unsigned b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd2: v = v;
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: v = '0;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_e(input logic regwr, input logic [1:0] src, input logic st, input int unsigned nb,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    i_ctrl_reg_wr_enE    = regwr;
    i_ctrl_result_srcE   = src;
    i_ctrl_mem_wr_enE    = st;
    i_ctrl_mem_byte_selE = (4'b0001 << nb) - 4'b0001;
    i_ctrl_funct3E       = f3;
    i_regfile_rd_addrE   = rd;
    i_alu_resultE        = addr;
    i_mem_writedataE     = wd;
    i_PCPlus4E           = pc;
  endtask

  task automatic set_e_random();
    set_e(1'($urandom), 2'($urandom), 1'($urandom), $urandom % 5, 3'($urandom), 5'($urandom),
          $urandom, $urandom, $urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    set_e_random();
    i_dmem_ack = 1'b1;
    i_dmem_rdata = $urandom;
    tick();
    tick();
    n_tests++; if (ctl !== 6'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 6'b0); end
    n_tests++;
    if ({o_dmem_byte_en, o_dmem_addr, o_dmem_wdata, o_read_dataM, o_alu_resultM, o_PCPlus4M,
         o_regfile_rd_addrM, o_ctrl_result_srcM} !== '0) begin
      n_fail++; $display("FAIL reset_data: addr %h wdata %h rdata %h alu %h pc %h", o_dmem_addr,
                         o_dmem_wdata, o_read_dataM, o_alu_resultM, o_PCPlus4M);
    end
    i_rst = 1'b0;
    i_dmem_ack = 1'b0;
  endtask

  task automatic test_store_word();
    set_e(1'b0, 2'b00, 1'b1, 4, 3'b010, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h1004);
    tick();
    i_dmem_ack = 1'b1;
    #1;
    n_tests++; if (ctl !== 6'b110000) begin n_fail++; $display("FAIL sw_ctl: got %b want %b", ctl, 6'b110000); end
    n_tests++; if (o_dmem_byte_en !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", o_dmem_byte_en); end
    n_tests++; if (o_dmem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", o_dmem_wdata); end
    n_tests++; if (o_dmem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 00000100", o_dmem_addr); end
  endtask

  task automatic test_byte_ops();
    set_e(1'b0, 2'b00, 1'b1, 1, 3'b000, 5'd0, 32'h103, 32'h0000_00A5, 32'h1008);
    tick();
    i_dmem_ack = 1'b1;
    #1;
    n_tests++; if (o_dmem_byte_en !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", o_dmem_byte_en); end
    n_tests++; if (o_dmem_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_dmem_wdata); end
    set_e(1'b1, 2'b01, 1'b0, 1, 3'b000, 5'd5, 32'h103, 32'h0, 32'h100C);
    tick();
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h8012_3456;
    #1;
    n_tests++; if (o_read_dataM !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", o_read_dataM); end
    n_tests++; if ({ctl, o_dmem_byte_en, o_dmem_wdata} !== {6'b100001, 4'b1000, 32'h0}) begin
      n_fail++; $display("FAIL lb_bus: got ctl %b be %b wd %h want 100001 1000 0", ctl, o_dmem_byte_en, o_dmem_wdata);
    end
    set_e(1'b1, 2'b01, 1'b0, 1, 3'b100, 5'd5, 32'h103, 32'h0, 32'h1010);
    tick();
    i_dmem_ack = 1'b1;
    #1;
    n_tests++; if (o_read_dataM !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", o_read_dataM); end
  endtask

  task automatic test_wait_half();
    int nstall;
    nstall = 0;
    set_e(1'b1, 2'b01, 1'b0, 2, 3'b001, 5'd7, 32'h102, 32'h0, 32'h2000);
    tick();
    set_e(1'b1, 2'b00, 1'b0, 0, 3'b000, 5'd9, 32'hABC, 32'h0, 32'h3000);
    for (int c = 0; c < 4; c++) begin
      i_dmem_ack   = (c == 3);
      i_dmem_rdata = (c == 3) ? 32'h8001_1234 : 32'h5555_5555;
      #1;
      if (o_stallM) nstall++;
      n_tests++;
      if ({o_dmem_addr, o_alu_resultM, o_regfile_rd_addrM, o_dmem_byte_en, o_dmem_req} !==
          {32'h100, 32'h102, 5'd7, 4'b1100, 1'b1}) begin
        n_fail++; $display("FAIL lh_hold: cycle %0d addr %h alu %h rd %0d be %b req %b", c,
                           o_dmem_addr, o_alu_resultM, o_regfile_rd_addrM, o_dmem_byte_en, o_dmem_req);
      end
      if (c < 3) tick();
    end
    n_tests++; if (o_read_dataM !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_data: got %h want ffff8001", o_read_dataM); end
    n_tests++; if (nstall !== 3) begin n_fail++; $display("FAIL lh_stall_cycles: got %0d want 3", nstall); end
    tick();
    i_dmem_ack = 1'b0;
    #1;
    n_tests++; if (o_alu_resultM !== 32'hABC) begin n_fail++; $display("FAIL lh_release: got %h want 00000abc", o_alu_resultM); end
  endtask

  task automatic test_misalign();
    set_e(1'b1, 2'b01, 1'b0, 4, 3'b010, 5'd3, 32'h101, 32'h0, 32'h4000);
    tick();
    i_dmem_ack = 1'b1;
    #1;
    n_tests++; if (ctl !== 6'b000100) begin n_fail++; $display("FAIL mis_ctl: got %b want 000100", ctl); end
    n_tests++; if (o_read_dataM !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", o_read_dataM); end
    set_e(1'b1, 2'b00, 1'b0, 0, 3'b000, 5'd4, 32'h44, 32'h0, 32'h4004);
    tick();
    i_dmem_ack = 1'b0;
    #1;
    n_tests++; if ({ctl, o_alu_resultM} !== {6'b000001, 32'h44}) begin
      n_fail++; $display("FAIL mis_next: got ctl %b alu %h want 000001 00000044", ctl, o_alu_resultM);
    end
  endtask

  task automatic test_timeout();
    int nstall, guard;
    nstall = 0;
    guard  = 0;
    i_dmem_ack = 1'b0;
    set_e(1'b1, 2'b01, 1'b0, 4, 3'b010, 5'd8, 32'h200, 32'h0, 32'h5000);
    tick();
    set_e(1'b1, 2'b00, 1'b0, 0, 3'b000, 5'd10, 32'h55, 32'h0, 32'h5004);
    while (!o_bus_errM && guard < 20) begin
      if (o_stallM) nstall++;
      tick();
      guard++;
    end
    n_tests++; if (o_bus_errM !== 1'b1) begin n_fail++; $display("FAIL tout_seen: got %b want 1 after %0d cycles", o_bus_errM, guard); end
    n_tests++; if (ctl !== 6'b000010) begin n_fail++; $display("FAIL tout_ctl: got %b want 000010", ctl); end
    n_tests++; if (o_read_dataM !== 32'h0) begin n_fail++; $display("FAIL tout_rdata: got %h want 0", o_read_dataM); end
    n_tests++; if (nstall !== TOUT) begin n_fail++; $display("FAIL tout_stall_cycles: got %0d want %0d", nstall, TOUT); end
    set_e(1'b1, 2'b00, 1'b0, 0, 3'b000, 5'd11, 32'h77, 32'h0, 32'h5008);
    tick();
    n_tests++; if ({ctl, o_alu_resultM} !== {6'b000001, 32'h77}) begin
      n_fail++; $display("FAIL tout_next: got ctl %b alu %h want 000001 00000077", ctl, o_alu_resultM);
    end
  endtask

  task automatic test_reset_mid();
    i_dmem_ack = 1'b0;
    set_e(1'b1, 2'b01, 1'b0, 4, 3'b010, 5'd12, 32'h300, 32'h0, 32'h6000);
    tick();
    set_e_random();
    tick();
    i_rst = 1'b1;
    tick();
    n_tests++; if (ctl !== 6'b0) begin n_fail++; $display("FAIL rstmid_ctl: got %b want 000000", ctl); end
    i_dmem_ack = 1'b1;
    i_dmem_rdata = $urandom;
    #1;
    n_tests++;
    if ({ctl, o_dmem_byte_en, o_dmem_addr, o_dmem_wdata, o_read_dataM, o_alu_resultM, o_PCPlus4M,
         o_regfile_rd_addrM, o_ctrl_result_srcM} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: ctl %b addr %h rdata %h alu %h", ctl, o_dmem_addr, o_read_dataM, o_alu_resultM);
    end
    i_rst = 1'b0;
    set_e(1'b1, 2'b01, 1'b0, 4, 3'b010, 5'd13, 32'h400, 32'h0, 32'h6004);
    tick();
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h1234_5678;
    #1;
    n_tests++; if ({ctl, o_read_dataM} !== {6'b100001, 32'h1234_5678}) begin
      n_fail++; $display("FAIL rstmid_idle: got ctl %b rdata %h want 100001 12345678", ctl, o_read_dataM);
    end
  endtask

  task automatic test_random();
    int unsigned kind, nb, d;
    logic [1:0]  src;
    logic        st, ld, regwr, mem, mis, req_e;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, wd, pc, rdata;
    logic [5:0]  exp_ctl;
    for (int k = 0; k < 60; k++) begin
      kind  = $urandom % 3;
      regwr = 1'($urandom);
      rd    = 5'($urandom);
      addr  = $urandom;
      wd    = $urandom;
      pc    = $urandom;
      d     = $urandom % TOUT;
      nb    = (($urandom % 3) == 0) ? 1 : ((($urandom % 2) == 0) ? 2 : 4);
      st    = (kind == 2);
      src   = (kind == 1) ? 2'b01 : ((($urandom % 2) == 0) ? 2'b00 : 2'b10);
      if (kind == 0) begin
        nb = $urandom % 3;
        f3 = 3'($urandom);
      end else if (kind == 2) begin
        f3 = (nb == 1) ? 3'd0 : ((nb == 2) ? 3'd1 : 3'd2);
      end else if (($urandom % 8) == 0) begin
        f3 = (($urandom % 2) == 0) ? 3'd3 : 3'd6;
      end else begin
        f3 = (nb == 1) ? 3'd0 : ((nb == 2) ? 3'd1 : 3'd2);
        if (nb != 4 && ($urandom % 2) == 1) f3 = f3 + 3'd4;
      end
      ld    = (src == 2'b01);
      mem   = ld || st;
      mis   = mem && ((addr % nb) != 0);
      req_e = mem && !mis;
      set_e(regwr, src, st, nb, f3, rd, addr, wd, pc);
      tick();
      set_e_random();
      for (int unsigned c = 0; c <= d; c++) begin
        rdata        = $urandom;
        i_dmem_rdata = rdata;
        i_dmem_ack   = req_e ? (c == d) : 1'($urandom);
        #1;
        exp_ctl = {req_e, req_e && st, req_e && (c < d), mis, 1'b0, regwr && !mis};
        n_tests++; if (ctl !== exp_ctl) begin n_fail++; $display("FAIL rnd_ctl: op %0d cyc %0d got %b want %b", k, c, ctl, exp_ctl); end
        n_tests++;
        if ({o_dmem_byte_en, o_dmem_addr, o_dmem_wdata} !== {m_be(nb, addr), addr & 32'hFFFF_FFFC, st ? m_wd(nb, wd) : 32'h0}) begin
          n_fail++; $display("FAIL rnd_bus: op %0d be %b addr %h wd %h want %b %h %h", k, o_dmem_byte_en, o_dmem_addr,
                             o_dmem_wdata, m_be(nb, addr), addr & 32'hFFFF_FFFC, st ? m_wd(nb, wd) : 32'h0);
        end
        n_tests++;
        if (o_read_dataM !== ((req_e && ld && c == d) ? m_ld(f3, addr, rdata) : 32'h0)) begin
          n_fail++; $display("FAIL rnd_rdata: op %0d f3 %0d addr %h bus %h got %h want %h", k, f3, addr, rdata,
                             o_read_dataM, (req_e && ld && c == d) ? m_ld(f3, addr, rdata) : 32'h0);
        end
        n_tests++;
        if ({o_alu_resultM, o_PCPlus4M, o_regfile_rd_addrM, o_ctrl_result_srcM} !== {addr, pc, rd, src}) begin
          n_fail++; $display("FAIL rnd_pass: op %0d alu %h pc %h rd %0d src %b want %h %h %0d %b", k, o_alu_resultM,
                             o_PCPlus4M, o_regfile_rd_addrM, o_ctrl_result_srcM, addr, pc, rd, src);
        end
        if (!req_e) break;
        if (c < d) tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_ops();
    test_wait_half();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
